// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, reset divisor and FSM state
// type for the burst clock divider.
package clkdiv_pkg;

  localparam int CNT_W       = 28;
  localparam int BURST_W     = 16;
  localparam int DEFAULT_DIV = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: period position counter plus registered
// CLOCK_OUT/TICK generation for the divided clock.
module clkdiv_counter #(
  parameter int CNT_W = clkdiv_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             active_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             boundary_o,
  output logic             clock_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  assign boundary_o  = run_i &&
    (cnt_q == divisor_i - CNT_W'(1));
  assign clock_out_o = clk_q;
  assign tick_o      = tick_q;

  // Next position; a new period always starts high, so the
  // current divisor is safe to use even across a change.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!active_i || load_i || boundary_o) begin
      cnt_d = '0;
    end
    clk_d  = active_i && (cnt_d < (divisor_i >> 1));
    tick_d = active_i && (cnt_d == '0);
  end

  // Position and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/clkdiv_seq.sv
// clkdiv_seq: burst clock divider with a config handshake,
// one-deep shadow for in-run divisor changes and stop control.
module clkdiv_seq #(
  parameter int CNT_W       = clkdiv_pkg::CNT_W,
  parameter int BURST_W     = clkdiv_pkg::BURST_W,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic               CLOCK_IN,
  input  logic               RESET_N,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  input  logic [CNT_W-1:0]   CFG_DIVISOR,
  input  logic [BURST_W-1:0] CFG_BURST,
  input  logic               START,
  input  logic               STOP,
  output logic               CLOCK_OUT,
  output logic               TICK,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  import clkdiv_pkg::state_e;
  import clkdiv_pkg::IDLE;
  import clkdiv_pkg::RUN;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] bur_q, bur_d;
  logic [BURST_W-1:0] pcnt_q, pcnt_d;
  logic               shv_q, shv_d;
  logic [CNT_W-1:0]   shdiv_q, shdiv_d;
  logic [BURST_W-1:0] shbur_q, shbur_d;
  logic               stop_q, stop_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               load;
  logic               fin;
  logic               bnd;
  logic               cfg_fire;
  logic               cfg_ok;

  assign CFG_READY = (state_q == IDLE) || !shv_q;
  assign BUSY      = (state_q == RUN);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign cfg_fire  = CFG_VALID && CFG_READY;
  assign cfg_ok    = CFG_DIVISOR >= CNT_W'(2);

  clkdiv_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (CLOCK_IN),
    .rst_n_i    (RESET_N),
    .run_i      (state_q == RUN),
    .active_i   (state_d == RUN),
    .load_i     (load),
    .divisor_i  (div_q),
    .boundary_o (bnd),
    .clock_out_o(CLOCK_OUT),
    .tick_o     (TICK)
  );

  // Next state, shadow handling and period bookkeeping.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bur_d   = bur_q;
    pcnt_d  = pcnt_q;
    shv_d   = shv_q;
    shdiv_d = shdiv_q;
    shbur_d = shbur_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    err_d   = err_q;
    load    = 1'b0;
    fin     = 1'b0;
    if (cfg_fire && !cfg_ok) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        stop_d = 1'b0;
        shv_d  = 1'b0;
        if (cfg_fire && cfg_ok) begin
          div_d = CFG_DIVISOR;
          bur_d = CFG_BURST;
        end
        if (START && !STOP) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          stop_d = 1'b1;
        end
        if (bnd) begin
          fin = (bur_q != '0) &&
            (pcnt_q + BURST_W'(1) == bur_q);
          if (shv_q) begin
            div_d  = shdiv_q;
            bur_d  = shbur_q;
            pcnt_d = '0;
            shv_d  = 1'b0;
          end else if (pcnt_q != '1) begin
            pcnt_d = pcnt_q + BURST_W'(1);
          end
          if (fin || stop_q) begin
            state_d = IDLE;
            done_d  = fin;
            pcnt_d  = '0;
            stop_d  = 1'b0;
          end
        end
        if (cfg_fire && cfg_ok) begin
          if (state_d == RUN) begin
            shv_d   = 1'b1;
            shdiv_d = CFG_DIVISOR;
            shbur_d = CFG_BURST;
          end else begin
            div_d = CFG_DIVISOR;
            bur_d = CFG_BURST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLOCK_IN) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      div_q   <= CNT_W'(DEFAULT_DIV);
      bur_q   <= '0;
      pcnt_q  <= '0;
      shv_q   <= 1'b0;
      shdiv_q <= '0;
      shbur_q <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bur_q   <= bur_d;
      pcnt_q  <= pcnt_d;
      shv_q   <= shv_d;
      shdiv_q <= shdiv_d;
      shbur_q <= shbur_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_seq.sv
// tb_clkdiv_seq: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model.
module tb_clkdiv_seq;

  localparam int CW = 28;
  localparam int BW = 16;

  logic          CLOCK_IN = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CFG_VALID = 1'b0;
  logic [CW-1:0] CFG_DIVISOR = '0;
  logic [BW-1:0] CFG_BURST = '0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          CFG_READY, CLOCK_OUT, TICK;
  logic          BUSY, DONE, ERR;

  int errs = 0;
  int checks = 0;
  bit chk_en = 0;

  // model state: position within period, active settings,
  // shadow and flags
  bit m_run, m_shv, m_stop, m_err, m_done;
  int m_ph, m_pc, m_div, m_bur, m_sd, m_sb;

  clkdiv_seq #(
    .CNT_W(CW), .BURST_W(BW), .DEFAULT_DIV(2)
  ) dut (
    .CLOCK_IN(CLOCK_IN), .RESET_N(RESET_N),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_DIVISOR(CFG_DIVISOR), .CFG_BURST(CFG_BURST),
    .START(START), .STOP(STOP),
    .CLOCK_OUT(CLOCK_OUT), .TICK(TICK), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLOCK_IN = ~CLOCK_IN;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model advanced on every rising edge.
  always @(posedge CLOCK_IN) begin
    bit acc, ok, was, fin, leave;
    if (!RESET_N) begin
      m_run = 0; m_shv = 0; m_stop = 0;
      m_err = 0; m_done = 0;
      m_ph = 0; m_pc = 0; m_div = 2; m_bur = 0;
    end else begin
      acc = CFG_VALID && (!m_run || !m_shv);
      ok = (CFG_DIVISOR >= 2);
      was = m_run;
      m_done = 0;
      if (acc && !ok) m_err = 1;
      if (!was) begin
        if (START && !STOP) begin
          m_run = 1; m_ph = 0; m_pc = 0;
        end
      end else begin
        if (m_ph == m_div - 1) begin
          fin = (m_bur != 0) && (m_pc + 1 == m_bur);
          leave = fin || m_stop;
          if (m_shv) begin
            m_div = m_sd; m_bur = m_sb;
            m_pc = 0; m_shv = 0;
          end else if (m_pc < (1 << BW) - 1) begin
            m_pc++;
          end
          if (leave) begin
            m_run = 0; m_pc = 0;
            m_stop = 0; m_done = fin;
          end
          m_ph = 0;
        end else begin
          m_ph++;
        end
        if (m_run && STOP) m_stop = 1;
      end
      if (acc && ok) begin
        if (was && m_run) begin
          m_shv = 1;
          m_sd = int'(CFG_DIVISOR);
          m_sb = int'(CFG_BURST);
        end else begin
          m_div = int'(CFG_DIVISOR);
          m_bur = int'(CFG_BURST);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLOCK_IN) begin
    if (chk_en) begin
      chk("clock_out", CLOCK_OUT,
          m_run && (m_ph < m_div / 2));
      chk("tick", TICK, m_run && (m_ph == 0));
      chk("busy", BUSY, m_run);
      chk("done", DONE, m_done);
      chk("err", ERR, m_err);
      chk("cfg_ready", CFG_READY, !m_run || !m_shv);
    end
  end

  task automatic step();
    @(posedge CLOCK_IN);
    @(negedge CLOCK_IN);
  endtask

  task automatic send_cfg(input int d, input int b);
    bit acc;
    int n;
    n = 0;
    CFG_VALID = 1;
    CFG_DIVISOR = CW'(d);
    CFG_BURST = BW'(b);
    do begin
      acc = CFG_READY;
      step();
      n++;
    end while (!acc && n < 50);
    CFG_VALID = 0;
    chk("cfg_accepted", acc, 1);
  endtask

  task automatic start_run();
    START = 1;
    step();
    START = 0;
  endtask

  task automatic stop_run();
    int n;
    n = 0;
    STOP = 1;
    step();
    STOP = 0;
    while (BUSY && n < 64) begin
      step();
      n++;
    end
    chk("stop_to_idle", BUSY, 0);
  endtask

  task automatic sample(input int n,
                        output logic [63:0] p,
                        output logic [63:0] t);
    p = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      p = {p[62:0], CLOCK_OUT};
      t = {t[62:0], TICK};
      if (i < n - 1) step();
    end
  endtask

  initial begin
    logic [63:0] p, t;
    step();
    chk_en = 1;
    step();
    chk("rst_clk", CLOCK_OUT, 0);
    chk("rst_tick", TICK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_ready", CFG_READY, 1);
    RESET_N = 1;
    step();

    // burst of three div-4 periods
    send_cfg(4, 3);
    start_run();
    sample(12, p, t);
    chk("burst_clk", p, 64'b110011001100);
    chk("burst_tick", t, 64'b100010001000);
    step();
    chk("burst_done", DONE, 1);
    chk("burst_idle", BUSY, 0);
    step();
    chk("done_pulse", DONE, 0);

    // free-running divide by 5
    send_cfg(5, 0);
    chk("idle_ready", CFG_READY, 1);
    start_run();
    sample(10, p, t);
    chk("div5_clk", p, 64'b1100011000);
    stop_run();

    // mid-run divisor change through the shadow
    send_cfg(4, 0);
    start_run();
    step();
    send_cfg(6, 0);
    CFG_VALID = 1;
    CFG_DIVISOR = CW'(8);
    CFG_BURST = '0;
    chk("shadow_full", CFG_READY, 0);
    step();
    chk("shadow_hold", CFG_READY, 0);
    step();
    chk("shadow_free", CFG_READY, 1);
    p = '0;
    p = {p[62:0], CLOCK_OUT};
    step();
    CFG_VALID = 0;
    chk("shadow_2nd", CFG_READY, 0);
    for (int i = 0; i < 5; i++) begin
      p = {p[62:0], CLOCK_OUT};
      step();
    end
    chk("div6_clk", p, 64'b111000);
    sample(8, p, t);
    chk("div8_clk", p, 64'b11110000);
    stop_run();

    // illegal divisor
    send_cfg(4, 0);
    send_cfg(1, 0);
    chk("err_set", ERR, 1);
    start_run();
    sample(8, p, t);
    chk("err_keepdiv", p, 64'b11001100);
    chk("err_sticky", ERR, 1);
    stop_run();

    // stop part-way through a div-8 period
    send_cfg(8, 0);
    start_run();
    p = '0;
    p = {p[62:0], CLOCK_OUT};
    step();
    p = {p[62:0], CLOCK_OUT};
    STOP = 1;
    step();
    STOP = 0;
    for (int i = 0; i < 6; i++) begin
      p = {p[62:0], CLOCK_OUT};
      step();
    end
    chk("stop_clk", p, 64'b11110000);
    chk("stop_idle", BUSY, 0);
    chk("stop_nodone", DONE, 0);
    START = 1;
    STOP = 1;
    step();
    START = 0;
    STOP = 0;
    chk("startstop", BUSY, 0);

    // reset in the middle of a run
    send_cfg(6, 0);
    start_run();
    step();
    step();
    RESET_N = 0;
    step();
    RESET_N = 1;
    chk("mid_rst_clk", CLOCK_OUT, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_err", ERR, 0);
    start_run();
    sample(4, p, t);
    chk("mid_rst_div2", p, 64'b1010);
    stop_run();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      RESET_N = ($urandom % 300) != 0;
      START = ($urandom % 8) == 0;
      STOP = ($urandom % 25) == 0;
      CFG_VALID = ($urandom % 5) == 0;
      CFG_DIVISOR = CW'($urandom_range(0, 9));
      CFG_BURST = BW'($urandom_range(0, 4));
      step();
    end
    RESET_N = 1;
    START = 0;
    STOP = 0;
    CFG_VALID = 0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
